// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer driving an external one-bit shifter.
// Optional: SHIFT_EARLY_EXIT_EN finishes early on fixed-point operands.
module shift_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] amt,
  input  logic             right,
  input  logic             arith,
  output logic [WIDTH-1:0] sh_in,
  output logic             sh_right,
  output logic             sh_arith,
  input  logic [WIDTH-1:0] sh_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic             r_ari;
  logic [WIDTH-1:0] r_dout;
  logic             w_exit;
  logic             w_last;

  // Early exit: shifting further cannot change acc
`ifdef SHIFT_EARLY_EXIT_EN
  always_comb begin
    w_exit = (r_acc == '0) ||
             (r_dir && r_ari && (r_acc == {WIDTH{1'b1}}));
  end
`else
  always_comb begin
    w_exit = 1'b0;
  end
`endif

  // Final shift pass when one count remains
  always_comb begin
    w_last = (r_cnt == CNT_W'(1));
  end

  // Sequencer state, accumulator, counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_ari   <= 1'b0;
      r_dout  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= din;
            r_cnt <= amt;
            r_dir <= right;
            r_ari <= arith;
            if (amt == '0) begin
              r_dout  <= din;
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          if (w_exit) begin
            r_dout  <= r_acc;
            r_state <= S_DONE;
          end else begin
            r_acc <= sh_out;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
              r_dout  <= sh_out;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from state or taken straight from registers
  always_comb begin
    sh_in    = r_acc;
    sh_right = r_dir;
    sh_arith = r_ari;
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_DONE);
    dout     = r_dout;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with a behavioural one-bit shifter.
// Directed table, hand-written corner sequences, random jobs.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [3:0]  amt;
  logic        right;
  logic        arith;
  logic [15:0] sh_in;
  logic        sh_right;
  logic        sh_arith;
  logic [15:0] sh_out;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  int n_pass;
  int n_total;

  shift_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .din      (din),
    .amt      (amt),
    .right    (right),
    .arith    (arith),
    .sh_in    (sh_in),
    .sh_right (sh_right),
    .sh_arith (sh_arith),
    .sh_out   (sh_out),
    .busy     (busy),
    .done     (done),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External one-bit shifter (log_SHIFT / ari_SHIFT plus mux)
  always_comb begin
    if (!sh_right)
      sh_out = {sh_in[14:0], 1'b0};
    else if (sh_arith)
      sh_out = {sh_in[15], sh_in[15:1]};
    else
      sh_out = {1'b0, sh_in[15:1]};
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [15:0] ref_result(input logic [15:0] d,
      input int a, input logic r, input logic ar);
    if (!r) return d << a;
    if (ar) return 16'($signed(d) >>> a);
    return d >> a;
  endfunction

  function automatic int ref_latency(input logic [15:0] d, input int a,
      input logic r, input logic ar);
`ifdef SHIFT_EARLY_EXIT_EN
    logic [15:0] v;
    for (int i = 0; i < a; i++) begin
      v = ref_result(d, i, r, ar);
      if (v == 16'h0) return i + 2;
      if (r && ar && v == 16'hFFFF) return i + 2;
    end
`endif
    return a + 1;
  endfunction

  // Run one job; optional stray start injected at cycle inj
  task automatic run_job(input logic [15:0] d, input logic [3:0] a,
      input logic r, input logic ar, input logic [15:0] exp_d,
      input int exp_lat, input int inj, input string tag);
    int lat;
    logic busy_ok;
    logic r0, a0;
    logic [15:0] got;
    @(negedge clk);
    start = 1'b1; din = d; amt = a; right = r; arith = ar;
    @(posedge clk);
    #1;
    start = 1'b0;
    din = 16'h0; amt = 4'h0; right = 1'b0; arith = 1'b0;
    lat = 0; busy_ok = 1'b1; got = 16'h0; r0 = 1'b0; a0 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, " sh_in"}, 32'(sh_in), 32'(d));
        r0 = sh_right; a0 = sh_arith;
        check({tag, " dir"}, {30'b0, sh_right, sh_arith}, {30'b0, r, ar});
      end
      if (k == inj) begin
        start = 1'b1; din = 16'hFFFF; amt = 4'hF;
        right = ~r; arith = ~ar;
      end
      if (k == inj + 1) begin
        start = 1'b0; din = 16'h0; amt = 4'h0;
        right = 1'b0; arith = 1'b0;
      end
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k; got = dout;
        break;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " dout"}, 32'(got), 32'(exp_d));
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " stable"}, {30'b0, sh_right, sh_arith}, {30'b0, r0, a0});
    @(negedge clk);
    check({tag, " idle"}, {30'b0, busy, done}, 32'd0);
    check({tag, " hold"}, 32'(dout), 32'(exp_d));
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  a;
    logic        r;
    logic        ar;
    logic [15:0] exp_d;
    int          lat;
    int          lat_ee;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat;
    n_pass = 0; n_total = 0;
    rst = 1'b1; start = 1'b0; din = 16'h0; amt = 4'h0;
    right = 1'b0; arith = 1'b0;

    tbl[0] = '{16'h8001, 4'd3,  1'b1, 1'b0, 16'h1000, 4,  4};
    tbl[1] = '{16'h8000, 4'd4,  1'b1, 1'b1, 16'hF800, 5,  5};
    tbl[2] = '{16'h0001, 4'd15, 1'b0, 1'b0, 16'h8000, 16, 16};
    tbl[3] = '{16'h1234, 4'd0,  1'b0, 1'b0, 16'h1234, 1,  1};
    tbl[4] = '{16'h0003, 4'd15, 1'b1, 1'b0, 16'h0000, 16, 4};
    tbl[5] = '{16'hFFFF, 4'd3,  1'b1, 1'b1, 16'hFFFF, 4,  2};
    tbl[6] = '{16'h0000, 4'd5,  1'b0, 1'b1, 16'h0000, 6,  2};
    tbl[7] = '{16'hC3A5, 4'd1,  1'b0, 1'b1, 16'h874A, 2,  2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outs", {busy, done, dout, sh_in, sh_right, sh_arith},
          34'h0);
    rst = 1'b0;

    foreach (tbl[i]) begin
`ifdef SHIFT_EARLY_EXIT_EN
      lat = tbl[i].lat_ee;
`else
      lat = tbl[i].lat;
`endif
      run_job(tbl[i].d, tbl[i].a, tbl[i].r, tbl[i].ar, tbl[i].exp_d,
              lat, 0, $sformatf("vec%0d", i));
    end

    // Stray start at T+2 of an amt=5 job must be ignored
    run_job(16'h00F0, 4'd5, 1'b0, 1'b0, 16'h1E00, 6, 2, "ignore");
    repeat (3) begin
      @(negedge clk);
      check("ignore no queue", {31'b0, busy}, 32'd0);
    end

    // Reset at T+2 of an amt=8 job
    @(negedge clk);
    start = 1'b1; din = 16'h0F0F; amt = 4'd8; right = 1'b0; arith = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rst busy T+1", {31'b0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst state", {busy, done, dout}, 18'h0);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) check("rst no done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("rst dout", 32'(dout), 32'd0);
    run_job(16'h00FF, 4'd4, 1'b0, 1'b0, 16'h0FF0, 5, 0, "after rst");

    // Random jobs against the reference model
    for (int n = 0; n < 60; n++) begin
      logic [15:0] d;
      logic [3:0]  a;
      logic        r, ar;
      case ($urandom_range(0, 5))
        0: d = 16'h0000;
        1: d = 16'hFFFF;
        2: d = 16'($urandom_range(0, 7));
        default: d = 16'($urandom);
      endcase
      a  = 4'($urandom_range(0, 15));
      r  = 1'($urandom);
      ar = 1'($urandom);
      run_job(d, a, r, ar, ref_result(d, int'(a), r, ar),
              ref_latency(d, int'(a), r, ar), 0,
              $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
